fifo_xfer_ctrl: RTL
===================

FIFO_XFER_CTRL -- requirements
Module: fifo_xfer_ctrl

Interface
REQ-001 The block SHALL have parameter LEN_WIDTH, default 16, the width of the transfer length and word counter.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have ports start, input, 1 bit, and dir, input, 1 bit: start begins a transfer; dir is 0 for TX (FIFO->engine) and 1 for RX (engine->FIFO).
REQ-005 The block SHALL have port len, input, LEN_WIDTH bits, the transfer length in 32-bit words.
REQ-006 The block SHALL have port abort, input, 1 bit, which terminates the active transfer.
REQ-007 The block SHALL have ports busy, output, 1 bit; done, output, 1 bit, a one-cycle completion pulse; aborted, output, 1 bit, a sticky abort status; and xfer_cnt, output, LEN_WIDTH bits, the words completed.
REQ-008 The block SHALL have FIFO read-side ports fifo_rd_en, output, 1 bit; fifo_rdata, input, 32 bits; and fifo_empty, input, 1 bit.
REQ-009 The block SHALL have FIFO write-side ports fifo_wr_en, output, 1 bit; fifo_wdata, output, 32 bits; and fifo_full, input, 1 bit.
REQ-010 The block SHALL have engine TX ports eng_tx_valid, output, 1 bit; eng_tx_data, output, 32 bits; and eng_tx_ready, input, 1 bit.
REQ-011 The block SHALL have engine RX ports eng_rx_valid, input, 1 bit; eng_rx_data, input, 32 bits; and eng_rx_ready, output, 1 bit.

Function
REQ-012 The FSM SHALL have states IDLE, TX_RD, TX_HOLD, RX and DONE; busy=1 in every state except IDLE.
REQ-013 In IDLE, start=1 SHALL latch len and dir, clear xfer_cnt and aborted, and go to TX_RD (dir=0) or RX (dir=1); if len=0 it SHALL go to DONE instead.
REQ-014 start SHALL be ignored in every state other than IDLE.
REQ-015 fifo_rd_en SHALL be combinational: (state==TX_RD) and not fifo_empty and not abort; when it is 1, the next state SHALL be TX_HOLD, otherwise the block stays in TX_RD.
REQ-016 FIFO read data is registered (valid the cycle after the rd_en edge and held until the next read), so eng_tx_data SHALL be driven directly from fifo_rdata and eng_tx_valid SHALL be 1 only in TX_HOLD.
REQ-017 In TX_HOLD, eng_tx_valid and eng_tx_ready both 1 SHALL increment xfer_cnt; the next state SHALL be DONE if the incremented count equals len, else TX_RD; eng_tx_valid SHALL stay 1 until that handshake completes.
REQ-018 TX throughput SHALL be at most one word per 2 cycles.
REQ-019 In RX, eng_rx_ready SHALL be combinational: not fifo_full and not abort.
REQ-020 In RX, fifo_wr_en SHALL equal eng_rx_valid and eng_rx_ready, with fifo_wdata = eng_rx_data; each such cycle SHALL increment xfer_cnt, and the last word SHALL move the FSM to DONE.
REQ-021 Outside their states, fifo_rd_en, fifo_wr_en, eng_tx_valid and eng_rx_ready SHALL be 0.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE; xfer_cnt SHALL hold its value until the next accepted start.
REQ-023 abort=1 in TX_RD, TX_HOLD or RX SHALL set aborted=1 and move the FSM to DONE on the next edge.
REQ-024 A TX_HOLD handshake in the same cycle as abort SHALL still be counted.
REQ-025 A word already popped but not yet handshaken when abort arrives SHALL be discarded and not counted.
REQ-026 abort SHALL have no effect in IDLE or DONE.
REQ-027 xfer_cnt SHALL never exceed len; counter arithmetic is LEN_WIDTH bits and len=2^LEN_WIDTH-1 SHALL be supported without wrap.

Reset
REQ-028 reset=1 SHALL, asynchronously, force the state to IDLE and set busy=0, done=0, aborted=0 and xfer_cnt=0.
REQ-029 Under reset, all combinational handshake outputs SHALL be 0 because the state is IDLE.
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer with no done pulse; FIFO contents are not the block's responsibility.

Verification
REQ-031 TX, len=4, FIFO preloaded with 0xA0..0xA3, eng_tx_ready=1 -> engine receives A0,A1,A2,A3 in order, one word per 2 cycles; done pulses once; xfer_cnt=4.
REQ-032 TX, len=3, FIFO initially empty, words pushed at cycles 5, 9 and 20 -> block stalls in TX_RD with no rd_en while empty; 3 words delivered; done follows the third handshake.
REQ-033 RX, len=5, eng_rx_valid=1 constant, fifo_full forced 1 for cycles 3-6 -> eng_rx_ready=0 and no fifo_wr_en while full; exactly 5 writes total; xfer_cnt=5.
REQ-034 TX, len=8, abort in TX_HOLD coincident with a handshake after 2 words -> xfer_cnt=3, aborted=1, done pulses next cycle, busy=0 after it.
REQ-035 start with len=0 -> done pulses on the next cycle, with no FIFO or engine activity and xfer_cnt=0.
REQ-036 reset asserted mid-RX (asynchronously, between edges) -> busy, done and xfer_cnt go to 0 immediately; a subsequent start operates normally.

Source files
------------

// File: rtl/fifo_xfer_ctrl_if.sv
// rtl/fifo_xfer_ctrl_if.sv - control, FIFO and engine signal bundle for fifo_xfer_ctrl
interface fifo_xfer_ctrl_if #(
    parameter int LEN_WIDTH = 16
);
    logic                 start;
    logic                 dir;
    logic [LEN_WIDTH-1:0] len;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic [LEN_WIDTH-1:0] xfer_cnt;

    logic                 fifo_rd_en;
    logic [31:0]          fifo_rdata;
    logic                 fifo_empty;
    logic                 fifo_wr_en;
    logic [31:0]          fifo_wdata;
    logic                 fifo_full;

    logic                 eng_tx_valid;
    logic [31:0]          eng_tx_data;
    logic                 eng_tx_ready;
    logic                 eng_rx_valid;
    logic [31:0]          eng_rx_data;
    logic                 eng_rx_ready;

    modport slave (
        input  start, dir, len, abort,
        input  fifo_rdata, fifo_empty, fifo_full,
        input  eng_tx_ready, eng_rx_valid, eng_rx_data,
        output busy, done, aborted, xfer_cnt,
        output fifo_rd_en, fifo_wr_en, fifo_wdata,
        output eng_tx_valid, eng_tx_data, eng_rx_ready
    );

    modport master (
        output start, dir, len, abort,
        output fifo_rdata, fifo_empty, fifo_full,
        output eng_tx_ready, eng_rx_valid, eng_rx_data,
        input  busy, done, aborted, xfer_cnt,
        input  fifo_rd_en, fifo_wr_en, fifo_wdata,
        input  eng_tx_valid, eng_tx_data, eng_rx_ready
    );
endinterface

// File: rtl/fifo_xfer_ctrl.sv
// rtl/fifo_xfer_ctrl.sv - moves len words between a FIFO and a streaming engine in either direction
module fifo_xfer_ctrl #(
    parameter int LEN_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    fifo_xfer_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, TX_RD, TX_HOLD, RX, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] cnt_q;
    logic [LEN_WIDTH-1:0] cnt_inc;
    logic                 aborted_q;
    logic                 active;
    logic                 rd_en;
    logic                 rx_ready;
    logic                 tx_hs;
    logic                 rx_hs;

    // Equality against len stops the count before it can wrap, even for len = all ones.
    assign cnt_inc  = cnt_q + LEN_WIDTH'(1);
    assign active   = (state == TX_RD) || (state == TX_HOLD) || (state == RX);
    assign rd_en    = (state == TX_RD) && !bus.fifo_empty && !bus.abort;
    assign rx_ready = (state == RX) && !bus.fifo_full && !bus.abort;
    assign tx_hs    = (state == TX_HOLD) && bus.eng_tx_ready;
    assign rx_hs    = rx_ready && bus.eng_rx_valid;

    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);
    assign bus.aborted      = aborted_q;
    assign bus.xfer_cnt     = cnt_q;
    assign bus.fifo_rd_en   = rd_en;
    assign bus.fifo_wr_en   = rx_hs;
    assign bus.fifo_wdata   = bus.eng_rx_data;
    assign bus.eng_tx_valid = (state == TX_HOLD);
    assign bus.eng_tx_data  = bus.fifo_rdata;
    assign bus.eng_rx_ready = rx_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0)  state_nxt = DONE;
                    else if (bus.dir)   state_nxt = RX;
                    else                state_nxt = TX_RD;
                end
            end
            TX_RD: begin
                if (bus.abort)      state_nxt = DONE;
                else if (rd_en)     state_nxt = TX_HOLD;
            end
            TX_HOLD: begin
                // An unacknowledged word is dropped on abort; an acknowledged one still counts.
                if (bus.abort)      state_nxt = DONE;
                else if (tx_hs)     state_nxt = (cnt_inc == len_q) ? DONE : TX_RD;
            end
            RX: begin
                if (bus.abort)                      state_nxt = DONE;
                else if (rx_hs && cnt_inc == len_q) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q     <= '0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                len_q     <= bus.len;
                cnt_q     <= '0;
                aborted_q <= 1'b0;
            end else begin
                if (tx_hs || rx_hs)       cnt_q     <= cnt_inc;
                if (active && bus.abort)  aborted_q <= 1'b1;
            end
        end
    end
endmodule
